mac_reg_arbiter: RTL and testbench
==================================

MAC_REG_ARBITER -- requirements
Module: mac_reg_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1024, WAIT-state cycle limit before abort (used only with MAC_REG_ARB_TIMEOUT_EN).
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  3  per-requester level request; bit k = requester k.
REQ-005 i_rdwn  input  3  per-requester direction; 1 = read, 0 = write.
REQ-006 i_addr  input  42  requester k address in bits [14k+13:14k].
REQ-007 i_wr_data  input  96  requester k write data in bits [32k+31:32k].
REQ-008 o_done  output  3  one-cycle completion pulse to the granted requester.
REQ-009 o_rd_data  output  32  shared read data, valid only while any o_done bit is high.
REQ-010 o_err  output  1  timeout flag, valid with o_done.
REQ-011 o_mac_request  output  1  one-cycle command pulse to the MAC register access port.
REQ-012 o_mac_rdwn  output  1  command direction.
REQ-013 o_mac_addr  output  14  command address.
REQ-014 o_mac_wr_data  output  32  command write data.
REQ-015 i_mac_done  input  1  one-cycle completion from the access port.
REQ-016 i_mac_rd_data  input  32  read data, valid with i_mac_done.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RELEASE.
REQ-018 IDLE, no requests: stay in IDLE.
REQ-019 IDLE, any i_req bit high: grant the first set bit searching round-robin from (last_grant+1) mod 3; register grant index, rdwn, addr and wr_data of the granted requester; go to ISSUE.
REQ-020 ISSUE: o_mac_request=1 for exactly this cycle; go to WAIT.
REQ-021 o_mac_rdwn, o_mac_addr and o_mac_wr_data come from the latched copy, are stable from ISSUE through WAIT, and are 0 in IDLE.
REQ-022 WAIT + i_mac_done: register i_mac_rd_data (reads) or 32'h0 (writes) into o_rd_data; set o_done[grant]=1 and o_err=0; update last_grant; go to RELEASE.
REQ-023 RELEASE: o_done and o_rd_data hold for exactly this cycle, then clear to 0; go to IDLE.
REQ-024 Requester protocol: hold i_req[k], addr, data and rdwn stable until o_done[k]; drop i_req[k] the cycle after o_done[k]; a still-high bit in IDLE is treated as a new request.
REQ-025 Minimum transaction: the grant cycle in IDLE plus ISSUE plus WAIT of at least 1 cycle plus RELEASE; o_done is high 1 cycle after i_mac_done.
REQ-026 i_mac_done in IDLE, ISSUE or RELEASE is discarded with no output change.
REQ-027 Request changes outside IDLE do not affect the current grant.
REQ-028 Only one o_done bit is ever high; o_mac_request never asserts outside ISSUE.

Reset
REQ-029 i_rst high at any clock edge, including mid-transaction: state=IDLE, last_grant=2 (requester 0 highest priority next), all outputs 0, latched command cleared, timeout counter cleared.
REQ-030 An outstanding command aborted by reset is not completed toward any requester.

Configuration
REQ-031 Macro MAC_REG_ARB_TIMEOUT_EN defined: a 16-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without i_mac_done: o_done[grant]=1, o_err=1, o_rd_data=32'hDEAD_BEEF, go to RELEASE. A late i_mac_done is discarded per REQ-026.
REQ-032 i_mac_done on the same cycle as timeout expiry wins: normal completion with o_err=0.
REQ-033 Macro undefined: no counter logic, o_err tied 0, WAIT waits indefinitely.

Verification
REQ-034 Single read: i_req=3'b001, addr0=14'h0010; access port returns i_mac_rd_data=32'h1234_5678 three cycles after o_mac_request -> o_mac_addr=14'h0010, o_mac_rdwn=1, o_done=3'b001 with o_rd_data=32'h1234_5678, o_err=0.
REQ-035 Single write: requester 2, wr_data=32'hA5A5_0001 -> o_mac_wr_data=32'hA5A5_0001, o_mac_rdwn=0, o_done=3'b100, o_rd_data=0.
REQ-036 Contention: i_req=3'b111 held (each bit dropped after its own done), starting after reset -> grant order 0,1,2; then re-raising bits 0 and 2 -> next grant 0.
REQ-037 Reset mid-WAIT: i_rst pulsed for 1 cycle while in WAIT -> all outputs 0 next cycle; later i_mac_done ignored; no o_done pulse.
REQ-038 With MAC_REG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, i_mac_done never returned -> o_done pulse after 16 WAIT cycles, o_err=1, o_rd_data=32'hDEAD_BEEF; a later stray i_mac_done causes no output change.
REQ-039 Stray i_mac_done in IDLE -> no output change; the next request completes normally.

Source files
------------

// File: rtl/mac_reg_arbiter.sv
// mac_reg_arbiter: round-robin arbiter that shares one MAC register access
// port among three requesters and returns completion, read data and error.
// Optional timeout abort of the WAIT state: define MAC_REG_ARB_TIMEOUT_EN.
module mac_reg_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_rdwn,
  input  logic [41:0] i_addr,
  input  logic [95:0] i_wr_data,
  output logic [2:0]  o_done,
  output logic [31:0] o_rd_data,
  output logic        o_err,
  output logic        o_mac_request,
  output logic        o_mac_rdwn,
  output logic [13:0] o_mac_addr,
  output logic [31:0] o_mac_wr_data,
  input  logic        i_mac_done,
  input  logic [31:0] i_mac_rd_data
);

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  logic [1:0]        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic [2:0]        done_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              mac_req_d;
  logic              mac_rdwn_d;
  logic [ADDR_W-1:0] mac_addr_d;
  logic [DATA_W-1:0] mac_wr_data_d;

`ifdef MAC_REG_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_d;
`endif

  // First set request bit searching upward from the one after last.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] p0, p1, p2;
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (req[p0])      rr_pick = p0;
    else if (req[p1]) rr_pick = p1;
    else              rr_pick = p2;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    logic [1:0] g;
    g             = 2'd0;
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    done_d        = 3'b000;
    rd_data_d     = '0;
    mac_req_d     = 1'b0;
    mac_rdwn_d    = o_mac_rdwn;
    mac_addr_d    = o_mac_addr;
    mac_wr_data_d = o_mac_wr_data;
`ifdef MAC_REG_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          g             = rr_pick(i_req, last_q);
          grant_d       = g;
          mac_req_d     = 1'b1;
          mac_rdwn_d    = i_rdwn[g];
          mac_addr_d    = i_addr[ADDR_W*g +: ADDR_W];
          mac_wr_data_d = i_wr_data[DATA_W*g +: DATA_W];
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MAC_REG_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (i_mac_done) begin
          done_d        = 3'(3'b001 << grant_q);
          rd_data_d     = o_mac_rdwn ? i_mac_rd_data : '0;
          last_d        = grant_q;
          mac_rdwn_d    = 1'b0;
          mac_addr_d    = '0;
          mac_wr_data_d = '0;
          state_d       = S_RELEASE;
        end
`ifdef MAC_REG_ARB_TIMEOUT_EN
        // A completion on the expiry cycle takes priority over the abort.
        else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          done_d        = 3'(3'b001 << grant_q);
          rd_data_d     = TIMEOUT_DATA;
          err_d         = 1'b1;
          last_d        = grant_q;
          mac_rdwn_d    = 1'b0;
          mac_addr_d    = '0;
          mac_wr_data_d = '0;
          state_d       = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      last_q        <= 2'd2;
      grant_q       <= 2'd0;
      o_done        <= 3'b000;
      o_rd_data     <= '0;
      o_mac_request <= 1'b0;
      o_mac_rdwn    <= 1'b0;
      o_mac_addr    <= '0;
      o_mac_wr_data <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      o_done        <= done_d;
      o_rd_data     <= rd_data_d;
      o_mac_request <= mac_req_d;
      o_mac_rdwn    <= mac_rdwn_d;
      o_mac_addr    <= mac_addr_d;
      o_mac_wr_data <= mac_wr_data_d;
    end
  end

`ifdef MAC_REG_ARB_TIMEOUT_EN
  // WAIT-state cycle counter and error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      o_err <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      o_err <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Self-checking bench for mac_reg_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin reference model.
module tb_mac_reg_arbiter;

  localparam logic [15:0] TO = 16'd16;

  logic        i_clk, i_rst;
  logic [2:0]  i_req, i_rdwn;
  logic [41:0] i_addr;
  logic [95:0] i_wr_data;
  logic [2:0]  o_done;
  logic [31:0] o_rd_data;
  logic        o_err, o_mac_request, o_mac_rdwn;
  logic [13:0] o_mac_addr;
  logic [31:0] o_mac_wr_data;
  logic        i_mac_done;
  logic [31:0] i_mac_rd_data;

  mac_reg_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_rdwn(i_rdwn),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .o_done(o_done),
    .o_rd_data(o_rd_data), .o_err(o_err), .o_mac_request(o_mac_request),
    .o_mac_rdwn(o_mac_rdwn), .o_mac_addr(o_mac_addr),
    .o_mac_wr_data(o_mac_wr_data), .i_mac_done(i_mac_done),
    .i_mac_rd_data(i_mac_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int tests_run = 0;
  int fails = 0;
  int m_last;

  logic [13:0] r_addr[3];
  logic [31:0] r_wdata[3];
  logic        r_rdwn[3];

  // Observations captured by the access-port driver.
  logic        t_timeout, t_stable, t_after_ok, t_rdwn, t_err;
  logic [13:0] t_addr;
  logic [31:0] t_wdata, t_rd;
  logic [2:0]  t_done;
  int          t_wait;

  // Reference arbitration: first requesting index after the last grant.
  function automatic int pick(input logic [2:0] req, input int last);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = (last + i) % 3;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply();
    for (int k = 0; k < 3; k++) begin
      i_addr[14*k +: 14]    = r_addr[k];
      i_wr_data[32*k +: 32] = r_wdata[k];
      i_rdwn[k]             = r_rdwn[k];
    end
  endtask

  task automatic randomize_reqs();
    for (int k = 0; k < 3; k++) begin
      r_addr[k]  = 14'($urandom);
      r_wdata[k] = $urandom;
      r_rdwn[k]  = 1'($urandom);
    end
    apply();
  endtask

  // Acts as the access port: waits for a command, answers after lat WAIT
  // cycles (never when lat < 0) and records what the arbiter did.
  task automatic do_txn(input int lat, input logic [31:0] rdata);
    int n;
    t_timeout = 1'b0; t_stable = 1'b1; t_wait = 0; t_done = 3'b000;
    n = 0;
    while (o_mac_request !== 1'b1 && n < 20) begin tick(); n++; end
    if (o_mac_request !== 1'b1) begin t_timeout = 1'b1; return; end
    t_addr = o_mac_addr; t_rdwn = o_mac_rdwn; t_wdata = o_mac_wr_data;
    if (lat >= 0) begin
      for (int i = 0; i < lat; i++) begin
        tick(); t_wait++;
        if (o_mac_request !== 1'b0 || o_done !== 3'b000 || o_mac_addr !== t_addr ||
            o_mac_rdwn !== t_rdwn || o_mac_wr_data !== t_wdata) t_stable = 1'b0;
      end
      i_mac_done = 1'b1; i_mac_rd_data = rdata;
      tick();
      i_mac_done = 1'b0; i_mac_rd_data = $urandom;
    end else begin
      forever begin
        tick(); t_wait++;
        if (o_done !== 3'b000 || t_wait > 100) break;
        if (o_mac_request !== 1'b0 || o_mac_addr !== t_addr ||
            o_mac_rdwn !== t_rdwn || o_mac_wr_data !== t_wdata) t_stable = 1'b0;
      end
    end
    t_done = o_done; t_rd = o_rd_data; t_err = o_err;
    i_req = i_req & ~o_done;
    tick();
    t_after_ok = (o_done === 3'b000 && o_rd_data === 32'h0 && o_err === 1'b0 &&
                  o_mac_addr === 14'h0 && o_mac_rdwn === 1'b0 && o_mac_wr_data === 32'h0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req = 3'b000;
    tick(); tick();
    tests_run++;
    if ({o_done, o_rd_data, o_err, o_mac_request, o_mac_rdwn, o_mac_addr, o_mac_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: done=%b rd=%h err=%b req=%b addr=%h expected all zero",
               o_done, o_rd_data, o_err, o_mac_request, o_mac_addr);
    end
    i_rst = 1'b0;
    tick(); tick();
    tests_run++;
    if ({o_done, o_mac_request, o_mac_addr} !== '0) begin
      fails++;
      $display("FAIL idle_no_req: done=%b req=%b addr=%h expected zero", o_done, o_mac_request, o_mac_addr);
    end
    m_last = 2;
  endtask

  task automatic test_single_read();
    randomize_reqs();
    r_addr[0] = 14'h0010; r_rdwn[0] = 1'b1; apply();
    i_req = 3'b001;
    do_txn(3, 32'h1234_5678);
    tests_run++;
    if (t_timeout || t_addr !== 14'h0010 || t_rdwn !== 1'b1) begin
      fails++;
      $display("FAIL read_cmd: timeout=%b addr=%h rdwn=%b expected addr=0010 rdwn=1", t_timeout, t_addr, t_rdwn);
    end
    tests_run++;
    if (t_done !== 3'b001 || t_rd !== 32'h1234_5678 || t_err !== 1'b0) begin
      fails++;
      $display("FAIL read_done: done=%b rd=%h err=%b expected 001 12345678 0", t_done, t_rd, t_err);
    end
    tests_run++;
    if (!t_stable || !t_after_ok) begin
      fails++;
      $display("FAIL read_timing: stable=%b cleared=%b expected 1 1", t_stable, t_after_ok);
    end
    m_last = 0;
  endtask

  task automatic test_single_write();
    randomize_reqs();
    r_wdata[2] = 32'hA5A5_0001; r_rdwn[2] = 1'b0; apply();
    i_req = 3'b100;
    do_txn(2, 32'hFFFF_FFFF);
    tests_run++;
    if (t_timeout || t_wdata !== 32'hA5A5_0001 || t_rdwn !== 1'b0 || t_addr !== r_addr[2]) begin
      fails++;
      $display("FAIL write_cmd: wdata=%h rdwn=%b addr=%h expected A5A50001 0 %h", t_wdata, t_rdwn, t_addr, r_addr[2]);
    end
    tests_run++;
    if (t_done !== 3'b100 || t_rd !== 32'h0 || t_err !== 1'b0) begin
      fails++;
      $display("FAIL write_done: done=%b rd=%h err=%b expected 100 00000000 0", t_done, t_rd, t_err);
    end
    m_last = 2;
  endtask

  task automatic test_contention();
    i_rst = 1'b1; tick(); i_rst = 1'b0; m_last = 2;
    randomize_reqs();
    i_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      int e;
      e = pick(i_req, m_last);
      do_txn(1 + k, $urandom);
      tests_run++;
      if (t_timeout || t_done !== 3'(1 << k) || t_addr !== r_addr[e]) begin
        fails++;
        $display("FAIL contention_grant%0d: done=%b addr=%h expected %b %h", k, t_done, t_addr, 3'(1 << k), r_addr[e]);
      end
      m_last = e;
    end
    i_req = 3'b101;
    do_txn(1, $urandom);
    tests_run++;
    if (t_done !== 3'b001) begin
      fails++;
      $display("FAIL contention_reraise: done=%b expected 001", t_done);
    end
    m_last = 0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    logic bad;
    randomize_reqs();
    r_rdwn[1] = 1'b1; apply();
    i_req = 3'b010;
    n = 0;
    while (o_mac_request !== 1'b1 && n < 20) begin tick(); n++; end
    tests_run++;
    if (o_mac_request !== 1'b1) begin
      fails++;
      $display("FAIL rst_wait_issue: mac_request=%b expected 1", o_mac_request);
    end
    tick(); tick();
    i_rst = 1'b1; i_req = 3'b000;
    tick();
    i_rst = 1'b0;
    tests_run++;
    if ({o_done, o_rd_data, o_err, o_mac_request, o_mac_rdwn, o_mac_addr, o_mac_wr_data} !== '0) begin
      fails++;
      $display("FAIL rst_wait_outputs: done=%b rd=%h req=%b addr=%h expected all zero",
               o_done, o_rd_data, o_mac_request, o_mac_addr);
    end
    tick();
    i_mac_done = 1'b1; i_mac_rd_data = $urandom;
    tick();
    i_mac_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_done !== 3'b000 || o_rd_data !== 32'h0 || o_mac_request !== 1'b0) bad = 1'b1;
      tick();
    end
    tests_run++;
    if (bad) begin
      fails++;
      $display("FAIL rst_wait_late_done: output activity seen=1 expected 0");
    end
    m_last = 2;
  endtask

  task automatic test_stray_done_idle();
    int e;
    logic [31:0] d;
    i_req = 3'b000;
    i_mac_done = 1'b1; i_mac_rd_data = 32'hCAFE_F00D;
    tick();
    i_mac_done = 1'b0;
    tests_run++;
    if ({o_done, o_rd_data, o_err, o_mac_request, o_mac_addr} !== '0) begin
      fails++;
      $display("FAIL stray_idle: done=%b rd=%h req=%b expected zero", o_done, o_rd_data, o_mac_request);
    end
    randomize_reqs();
    r_rdwn[1] = 1'b1; apply();
    i_req = 3'b010;
    e = pick(i_req, m_last);
    d = $urandom;
    do_txn(2, d);
    tests_run++;
    if (t_done !== 3'(1 << e) || t_rd !== d || t_err !== 1'b0) begin
      fails++;
      $display("FAIL stray_next_txn: done=%b rd=%h err=%b expected %b %h 0", t_done, t_rd, t_err, 3'(1 << e), d);
    end
    m_last = e;
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int e, lat;
      logic [31:0] d, exp_rd;
      randomize_reqs();
      i_req = 3'($urandom_range(1, 7));
      e = pick(i_req, m_last);
      lat = $urandom_range(1, 5);
      d = $urandom;
      exp_rd = r_rdwn[e] ? d : 32'h0;
      do_txn(lat, d);
      tests_run++;
      if (t_timeout || t_done !== 3'(1 << e) || t_rd !== exp_rd || t_err !== 1'b0) begin
        fails++;
        $display("FAIL random%0d_done: done=%b rd=%h err=%b expected %b %h 0", it, t_done, t_rd, t_err, 3'(1 << e), exp_rd);
      end
      tests_run++;
      if (t_addr !== r_addr[e] || t_rdwn !== r_rdwn[e] || t_wdata !== r_wdata[e] || !t_stable || !t_after_ok) begin
        fails++;
        $display("FAIL random%0d_cmd: addr=%h rdwn=%b wdata=%h stable=%b cleared=%b expected %h %b %h 1 1",
                 it, t_addr, t_rdwn, t_wdata, t_stable, t_after_ok, r_addr[e], r_rdwn[e], r_wdata[e]);
      end
      m_last = e;
      i_req = 3'b000;
    end
  endtask

`ifdef MAC_REG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int e;
    logic [31:0] d;
    randomize_reqs();
    r_rdwn[0] = 1'b1; apply();
    i_req = 3'b001;
    e = pick(i_req, m_last);
    do_txn(-1, 32'h0);
    // TO WAIT cycles, then one more edge into RELEASE.
    tests_run++;
    if (t_wait != int'(TO) + 1 || t_done !== 3'(1 << e) || t_err !== 1'b1 || t_rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL timeout_abort: edges=%0d done=%b err=%b rd=%h expected %0d %b 1 deadbeef",
               t_wait, t_done, t_err, t_rd, int'(TO) + 1, 3'(1 << e));
    end
    m_last = e;
    i_mac_done = 1'b1; i_mac_rd_data = $urandom;
    tick();
    i_mac_done = 1'b0;
    tests_run++;
    if ({o_done, o_rd_data, o_err, o_mac_request} !== '0) begin
      fails++;
      $display("FAIL timeout_late_done: done=%b rd=%h err=%b expected zero", o_done, o_rd_data, o_err);
    end
    i_req = 3'b001;
    e = pick(i_req, m_last);
    d = $urandom;
    do_txn(int'(TO), d);
    tests_run++;
    if (t_done !== 3'(1 << e) || t_err !== 1'b0 || t_rd !== d) begin
      fails++;
      $display("FAIL timeout_same_cycle: done=%b err=%b rd=%h expected %b 0 %h", t_done, t_err, t_rd, 3'(1 << e), d);
    end
    m_last = e;
  endtask
`else
  task automatic test_long_wait();
    int e;
    logic [31:0] d;
    randomize_reqs();
    r_rdwn[1] = 1'b1; apply();
    i_req = 3'b010;
    e = pick(i_req, m_last);
    d = $urandom;
    do_txn(60, d);
    tests_run++;
    if (!t_stable || t_done !== 3'(1 << e) || t_err !== 1'b0 || t_rd !== d) begin
      fails++;
      $display("FAIL long_wait: stable=%b done=%b err=%b rd=%h expected 1 %b 0 %h", t_stable, t_done, t_err, t_rd, 3'(1 << e), d);
    end
    m_last = e;
  endtask
`endif

  initial begin
    i_rst = 1'b1; i_req = 3'b000; i_rdwn = 3'b000; i_addr = '0; i_wr_data = '0;
    i_mac_done = 1'b0; i_mac_rd_data = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_reset_mid_wait();
    test_stray_done_idle();
    test_random();
`ifdef MAC_REG_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
